// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
//   Debounces four active-low push buttons, turns each accepted press into a
//   toggle flip plus a pending event, and offers pending events one at a time
//   on a valid/ready channel using round-robin arbitration.
//
//   clk       : rising-edge system clock
//   rst       : asynchronous active-high reset
//   btn[3:0]  : raw buttons, active low, asynchronous to clk
//   evt_ready : consumer accepts the offered event
//   evt_valid : an event is offered on evt_id
//   evt_id    : index of the offered button
//   toggle_q  : per-button toggle, flips once per accepted press
//   overflow  : one-cycle pulse when a press hits an already pending button
// -----------------------------------------------------------------------------

// Per-button synchronizer + debouncer. o_press is a one-cycle strobe that is
// high in the cycle whose closing edge sets the debounced state 0->1.
module button_event_debounce #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CW              = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_stable,
    output logic o_press
);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1, r_sync2, r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_flip;

    assign w_flip   = (r_sync2 != r_stable) && (r_cnt == CNT_MAX);
    assign o_press  = w_flip && !r_stable;
    assign o_stable = r_stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= ~i_btn_n;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

module button_event_arbiter #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_id,
    output logic [3:0] toggle_q,
    output logic       overflow
);
    localparam int NUM_LANES = 4;

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t               r_state;
    logic [NUM_LANES-1:0] r_pending, r_toggle;
    logic [1:0]           r_last, r_evt_id;
    logic                 r_evt_valid, r_overflow;

    logic [NUM_LANES-1:0] w_stable, w_press, w_clr;
    logic [1:0]           w_win, w_idx;
    logic                 w_found, w_any, w_grant;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        button_event_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk      (clk),
            .rst      (rst),
            .i_btn_n  (btn[g]),
            .o_stable (w_stable[g]),
            .o_press  (w_press[g])
        );
    end

    // Round robin: scan upward starting one past the last granted button.
    always_comb begin
        w_win   = r_last + 2'd1;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && r_pending[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_any   = |r_pending;
    // A new winner is taken from IDLE, or from OFFER on the handshake edge.
    assign w_grant = w_any && ((r_state == S_IDLE) || evt_ready);
    assign w_clr   = w_grant ? (NUM_LANES'(1) << w_win) : '0;

    // Press is OR-ed after the grant clear so a press landing on the grant
    // edge of the same button survives; only a press onto a still-pending
    // (not being cleared) bit is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_toggle   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_clr) | w_press;
            r_toggle   <= r_toggle ^ w_press;
            r_overflow <= |(w_press & r_pending & ~w_clr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 2'd3;
            r_evt_id    <= '0;
            r_evt_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_evt_id    <= w_win;
                        r_last      <= w_win;
                        r_evt_valid <= 1'b1;
                        r_state     <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (evt_ready) begin
                        if (w_any) begin
                            r_evt_id <= w_win;
                            r_last   <= w_win;
                        end else begin
                            r_evt_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_evt_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign toggle_q  = r_toggle;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] toggle_q;
    logic       overflow;

    int n_chk  = 0;
    int n_fail = 0;

    button_event_arbiter #(.DEBOUNCE_CYCLES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .toggle_q  (toggle_q),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] id,
                           input logic [3:0] tq, input logic ov);
        chk({tag, ".valid"}, {3'b0, evt_valid}, {3'b0, v});
        chk({tag, ".id"},    {2'b0, evt_id},    {2'b0, id});
        chk({tag, ".toggle"}, toggle_q, tq);
        chk({tag, ".ovf"},   {3'b0, overflow},  {3'b0, ov});
    endtask

    // Assert reset between edges and check the outputs clear without a clock.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #2;
        chk_out(tag, 1'b0, 2'd0, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn = 4'hF; evt_ready = 1'b0;
        step(2);
        chk_out("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        rst = 1'b0;

        // Single press of button 0, consumer always ready.
        evt_ready = 1'b1;
        btn = 4'b1110;
        step(4); chk("p0.e4.toggle", toggle_q, 4'b0000);
        step(1); chk_out("p0.e5", 1'b0, 2'd0, 4'b0001, 1'b0);
        step(1); chk_out("p0.e6", 1'b1, 2'd0, 4'b0001, 1'b0);
        step(1); chk_out("p0.e7", 1'b0, 2'd0, 4'b0001, 1'b0);
        btn = 4'b1111;
        step(6); chk_out("p0.release", 1'b0, 2'd0, 4'b0001, 1'b0);

        // Two-sample glitch must be filtered.
        btn = 4'b1110;
        step(2);
        btn = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk_out("glitch", 1'b0, 2'd0, 4'b0001, 1'b0);
        end

        async_reset("rst1");

        // All four pressed together: back-to-back grants 0,1,2,3.
        evt_ready = 1'b1;
        btn = 4'b0000;
        step(5); chk_out("all.e5", 1'b0, 2'd0, 4'b1111, 1'b0);
        step(1); chk_out("all.e6", 1'b1, 2'd0, 4'b1111, 1'b0);
        step(1); chk_out("all.e7", 1'b1, 2'd1, 4'b1111, 1'b0);
        step(1); chk_out("all.e8", 1'b1, 2'd2, 4'b1111, 1'b0);
        step(1); chk_out("all.e9", 1'b1, 2'd3, 4'b1111, 1'b0);
        step(1); chk_out("all.e10", 1'b0, 2'd3, 4'b1111, 1'b0);
        btn = 4'b1111;
        step(6); chk_out("all.release", 1'b0, 2'd3, 4'b1111, 1'b0);

        async_reset("rst2");

        // Stalled consumer: button 1 occupies the offer while button 2 is
        // pressed, released and pressed again -> second press overflows.
        evt_ready = 1'b0;
        btn = 4'b1101;
        step(5); chk_out("stall.b1.e5", 1'b0, 2'd0, 4'b0010, 1'b0);
        step(1); chk_out("stall.b1.e6", 1'b1, 2'd1, 4'b0010, 1'b0);
        btn = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall.b2a.ovf", {3'b0, overflow}, 4'h0);
        end
        chk_out("stall.b2a.e5", 1'b1, 2'd1, 4'b0110, 1'b0);
        btn = 4'b1101;
        step(6); chk_out("stall.b2.rel", 1'b1, 2'd1, 4'b0110, 1'b0);
        btn = 4'b1001;
        step(4); chk_out("stall.b2b.e4", 1'b1, 2'd1, 4'b0110, 1'b0);
        step(1); chk_out("stall.b2b.e5", 1'b1, 2'd1, 4'b0010, 1'b1);
        step(1); chk_out("stall.b2b.e6", 1'b1, 2'd1, 4'b0010, 1'b0);
        evt_ready = 1'b1;
        step(1); chk_out("stall.hs1", 1'b1, 2'd2, 4'b0010, 1'b0);
        step(1); chk_out("stall.hs2", 1'b0, 2'd2, 4'b0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall.single", {3'b0, evt_valid}, 4'h0);
        end
        btn = 4'b1111;
        step(6); chk_out("stall.release", 1'b0, 2'd2, 4'b0010, 1'b0);

        // Reset while offering with others pending; last grant was 2 -> 3 next.
        evt_ready = 1'b0;
        btn = 4'b0000;
        step(5); chk_out("mid.e5", 1'b0, 2'd2, 4'b1101, 1'b0);
        step(1); chk_out("mid.e6", 1'b1, 2'd3, 4'b1101, 1'b0);
        btn = 4'b1111;
        async_reset("mid.rst");
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("mid.noevt", {3'b0, evt_valid}, 4'h0);
        end

        // Button 3 held through reset is seen as a fresh press.
        rst = 1'b1;
        btn = 4'b0111;
        step(2);
        rst = 1'b0;
        step(4); chk_out("held.e4", 1'b0, 2'd0, 4'b0000, 1'b0);
        step(1); chk_out("held.e5", 1'b0, 2'd0, 4'b1000, 1'b0);
        step(1); chk_out("held.e6", 1'b1, 2'd3, 4'b1000, 1'b0);
        step(1); chk_out("held.e7", 1'b0, 2'd3, 4'b1000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
